// File: rtl/rx_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rx_pkg
// Description : Shared types and constants for the RX stream arbiter:
//               FSM state encoding and the statistics saturation value.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic [15:0] C_STAT_MAX = 16'hFFFF;

endpackage : rx_pkg
`default_nettype wire

// File: rtl/rx_stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches the request
//               vector cyclically starting at the pointer and returns the
//               first requester as a one-hot grant plus its index.
// Ports       : req   - request vector, one bit per port
//               ptr   - search start index (always < G_NUM_PORTS)
//               grant - one-hot winner, all zero when no request
//               idx   - binary index of the winner
//               any   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int G_NUM_PORTS = 2,
  parameter int IDX_W       = $clog2(G_NUM_PORTS)
) (
  input  logic [G_NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [G_NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  always_comb begin : p_pick
    int w_port;
    w_port = 0;
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < G_NUM_PORTS; i++) begin
      w_port = (int'(ptr) + i) % G_NUM_PORTS;
      if (!any && req[w_port]) begin
        any           = 1'b1;
        grant[w_port] = 1'b1;
        idx           = IDX_W'(w_port);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rx_stream_arbiter
// Description : Packet-atomic round-robin arbiter sharing one byte-wide
//               AXI-Stream sink between G_NUM_PORTS receive streams. A grant
//               lasts one whole packet; packets longer than G_MAX_PKT_LEN get
//               a forced tlast and their remaining bytes are drained.
// Ports       : clk_in, rst_in (async, active-high)
//               s_tdata_in/s_tvalid_in/s_tlast_in/s_tready_out - per-port sinks
//               m_tdata_out/m_tvalid_out/m_tlast_out/m_tready_in - shared source
//               grant_out      - one-hot active port, zero when idle
//               stat_trunc_cnt - saturating count of truncated packets
// Revision    : 1.0 - initial release
// ============================================================================
module rx_stream_arbiter
  import rx_pkg::*;
#(
  parameter int G_NUM_PORTS   = 2,
  parameter int G_MAX_PKT_LEN = 512
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [8*G_NUM_PORTS-1:0] s_tdata_in,
  input  logic [G_NUM_PORTS-1:0]   s_tvalid_in,
  input  logic [G_NUM_PORTS-1:0]   s_tlast_in,
  output logic [G_NUM_PORTS-1:0]   s_tready_out,
  output logic [7:0]               m_tdata_out,
  output logic                     m_tvalid_out,
  output logic                     m_tlast_out,
  input  logic                     m_tready_in,
  output logic [G_NUM_PORTS-1:0]   grant_out,
  output logic [15:0]              stat_trunc_cnt
);

  localparam int C_IDX_W = $clog2(G_NUM_PORTS);
  localparam int C_CNT_W = $clog2(G_MAX_PKT_LEN + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(G_MAX_PKT_LEN - 1);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(G_NUM_PORTS - 1);

  arb_state_t             r_state;
  logic [C_IDX_W-1:0]     r_ptr;
  logic [C_IDX_W-1:0]     r_gidx;
  logic [G_NUM_PORTS-1:0] r_grant;
  logic [C_CNT_W-1:0]     r_cnt;
  logic [15:0]            r_stat;

  logic [G_NUM_PORTS-1:0] w_pick_grant;
  logic [C_IDX_W-1:0]     w_pick_idx;
  logic                   w_pick_any;
  logic [C_IDX_W+2:0]     w_base;
  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic                   w_force_last;
  logic [C_IDX_W-1:0]     w_next_ptr;

  rr_pick #(
    .G_NUM_PORTS (G_NUM_PORTS),
    .IDX_W       (C_IDX_W)
  ) u_pick (
    .req   (s_tvalid_in),
    .ptr   (r_ptr),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  // Byte lane base of the granted port; widened so the multiply-by-8 never truncates.
  assign w_base       = {r_gidx, 3'b000};
  assign w_sel_valid  = s_tvalid_in[r_gidx];
  assign w_sel_last   = s_tlast_in[r_gidx];
  assign w_force_last = (r_cnt == C_LAST_CNT);
  assign w_next_ptr   = (r_gidx == C_LAST_IDX) ? '0 : r_gidx + C_IDX_W'(1);

  assign grant_out      = r_grant;
  assign stat_trunc_cnt = r_stat;

  // Output mux depends only on registered state/grant plus the selected
  // inputs, so m_tvalid never sees m_tready combinationally.
  always_comb begin
    s_tready_out = '0;
    m_tdata_out  = '0;
    m_tvalid_out = 1'b0;
    m_tlast_out  = 1'b0;
    case (r_state)
      PASS: begin
        m_tdata_out  = s_tdata_in[w_base +: 8];
        m_tvalid_out = w_sel_valid;
        m_tlast_out  = w_sel_last | w_force_last;
        s_tready_out = r_grant & {G_NUM_PORTS{m_tready_in}};
      end
      DRAIN: begin
        s_tready_out = r_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_stat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_grant;
            r_gidx  <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_sel_valid && m_tready_in) begin
            if (w_sel_last) begin
              // A real tlast wins even when it lands on the length limit.
              r_state <= IDLE;
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
              r_cnt   <= '0;
            end else if (w_force_last) begin
              r_state <= DRAIN;
              r_cnt   <= '0;
              if (r_stat != C_STAT_MAX) begin
                r_stat <= r_stat + 16'd1;
              end
            end else begin
              r_cnt <= r_cnt + C_CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_sel_valid && w_sel_last) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule : rx_stream_arbiter
`default_nettype wire

// File: tb/tb_rx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_stream_arbiter
// Description : Self-checking bench for rx_stream_arbiter. Sources present
//               random packets; a packet-level round-robin model predicts the
//               served order and the forwarded (possibly truncated) bytes into
//               a scoreboard, which a separate monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_stream_arbiter;

  localparam int NP = 3;
  localparam int ML = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8*NP-1:0] s_tdata;
  logic [NP-1:0]   s_tvalid;
  logic [NP-1:0]   s_tlast;
  logic [NP-1:0]   s_tready;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [NP-1:0]   grant;
  logic [15:0]     stat;

  always #5 clk = ~clk;

  rx_stream_arbiter #(
    .G_NUM_PORTS   (NP),
    .G_MAX_PKT_LEN (ML)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .s_tdata_in     (s_tdata),
    .s_tvalid_in    (s_tvalid),
    .s_tlast_in     (s_tlast),
    .s_tready_out   (s_tready),
    .m_tdata_out    (m_tdata),
    .m_tvalid_out   (m_tvalid),
    .m_tlast_out    (m_tlast),
    .m_tready_in    (m_tready),
    .grant_out      (grant),
    .stat_trunc_cnt (stat)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int tests = 0;
  int fails = 0;

  // source state
  logic [7:0] pkt [NP][$];
  int         pos [NP];
  bit         active [NP];
  bit         present [NP];
  bit         hs_r [NP];
  int         left [NP];
  bit         gen_en;

  // packet-level reference model
  bit    arb_idle;
  int    ptr_m;
  int    g_m;
  int    trunc_m;
  int    out_beats;
  beat_t exp_q[$];
  beat_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p] = active[p] && present[p];
      if (active[p]) begin
        s_tdata[8*p +: 8] = pkt[p][pos[p]];
        s_tlast[p]        = (pos[p] == pkt[p].size() - 1);
      end else begin
        s_tdata[8*p +: 8] = 8'($urandom);
        s_tlast[p]        = 1'b0;
      end
    end
  endtask

  task automatic start_pkt(input int p, input int len);
    pkt[p].delete();
    for (int i = 0; i < len; i++) pkt[p].push_back(8'($urandom));
    pos[p]    = 0;
    active[p] = 1'b1;
  endtask

  function automatic int rand_len();
    case ($urandom_range(0, 5))
      0:       return ML;
      1:       return ML + 1;
      2:       return ML - 1;
      3:       return 1;
      default: return int'($urandom_range(2, 2*ML + 8));
    endcase
  endfunction

  function automatic bit all_quiet();
    bit q;
    q = arb_idle && (exp_q.size() == 0);
    for (int p = 0; p < NP; p++) if (active[p]) q = 1'b0;
    return q;
  endfunction

  // Evaluated at the negedge: inputs are stable, so the sampled handshakes
  // are the ones that complete at the coming posedge.
  task automatic model_step();
    int len;
    int n;
    bit found;
    beat_t b;
    for (int p = 0; p < NP; p++) hs_r[p] = s_tvalid[p] && s_tready[p];
    if (arb_idle) begin
      chk("idle_grant", 32'(grant), 0);
      chk("idle_s_tready", 32'(s_tready), 0);
      chk("idle_m_tvalid", 32'(m_tvalid), 0);
      chk("stat_trunc_cnt", 32'(stat), 32'(trunc_m));
      if (s_tvalid != '0) begin
        found = 1'b0;
        for (int i = 0; i < NP; i++) begin
          if (!found && s_tvalid[(ptr_m + i) % NP]) begin
            found = 1'b1;
            g_m   = (ptr_m + i) % NP;
          end
        end
        arb_idle = 1'b0;
        len      = pkt[g_m].size();
        n        = (len < ML) ? len : ML;
        for (int i = 0; i < n; i++) begin
          b.d = pkt[g_m][i];
          b.l = (i == n - 1);
          exp_q.push_back(b);
        end
        if (len > ML) trunc_m++;
        ptr_m = (g_m + 1) % NP;
      end
    end else begin
      chk("grant_onehot", 32'(grant), 32'(1) << g_m);
      for (int p = 0; p < NP; p++)
        if (p != g_m) chk("other_s_tready", 32'(s_tready[p]), 0);
      if (pos[g_m] >= ML) begin
        chk("drain_m_tvalid", 32'(m_tvalid), 0);
        chk("drain_s_tready", 32'(s_tready[g_m]), 1);
      end else begin
        chk("pass_s_tready", 32'(s_tready[g_m]), 32'(m_tready));
      end
      if (hs_r[g_m] && (pos[g_m] == pkt[g_m].size() - 1)) arb_idle = 1'b1;
    end
  endtask

  task automatic update_sources();
    for (int p = 0; p < NP; p++) begin
      if (hs_r[p]) begin
        pos[p]++;
        present[p] = 1'b0;
        if (pos[p] == pkt[p].size()) active[p] = 1'b0;
      end
      hs_r[p] = 1'b0;
      if (!active[p] && gen_en && left[p] > 0 && $urandom_range(0, 5) == 0) begin
        start_pkt(p, rand_len());
        left[p]--;
      end
      if (active[p] && !present[p]) present[p] = ($urandom_range(0, 3) != 0);
    end
    m_tready = ($urandom_range(0, 3) != 0);
    drive_inputs();
  endtask

  task automatic flush_bench();
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      pkt[p].delete();
      active[p]  = 1'b0;
      present[p] = 1'b0;
      pos[p]     = 0;
      hs_r[p]    = 1'b0;
    end
    arb_idle = 1'b1;
    ptr_m    = 0;
    trunc_m  = 0;
    drive_inputs();
  endtask

  // Returns at posedge+2 so the caller can launch stimulus safely.
  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (!all_quiet() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL wait_quiet: timed out after %0d cycles, expected idle with empty scoreboard", n);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input int p, input int len);
    start_pkt(p, len);
    present[p] = 1'b1;
    drive_inputs();
  endtask

  // stimulus driver + reference model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) model_step();
      @(posedge clk);
      #1;
      if (!rst) update_sources();
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid && m_tready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %02h last %0b, expected no beat", m_tdata, m_tlast);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 32'(m_tdata), 32'(mon_e.d));
          chk("beat_last", 32'(m_tlast), 32'(mon_e.l));
        end
      end
    end
  end

  initial begin
    int b0;
    int n;
    bit busy;
    s_tdata   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    m_tready  = 1'b0;
    gen_en    = 1'b0;
    out_beats = 0;
    for (int p = 0; p < NP; p++) left[p] = 0;
    flush_bench();

    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_stat", 32'(stat), 0);
    rst = 1'b0;

    // single packet, then simultaneous requests, then length boundaries
    @(posedge clk); #2;
    launch(0, 10);
    wait_quiet(500);
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NP; p++) launch(p, 4);
      wait_quiet(500);
    end
    launch(0, ML + 9);
    wait_quiet(500);
    launch(1, ML);
    wait_quiet(500);
    launch(2, ML + 1);
    wait_quiet(500);

    // randomized traffic
    for (int p = 0; p < NP; p++) left[p] = 25;
    gen_en = 1'b1;
    n = 0;
    busy = 1'b1;
    while (busy && n < 20000) begin
      @(posedge clk);
      n++;
      busy = 1'b0;
      for (int p = 0; p < NP; p++) if (left[p] > 0) busy = 1'b1;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL random_phase: timed out with packets still pending");
    end
    gen_en = 1'b0;
    wait_quiet(3000);

    // move the pointer off 0, then abort a packet with reset
    launch(0, 3);
    wait_quiet(500);
    b0 = out_beats;
    launch(1, 20);
    n = 0;
    while (out_beats < b0 + 5 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL reset_prep: only %0d beats seen, expected 5", out_beats - b0);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_m_tvalid", 32'(m_tvalid), 0);
    chk("async_rst_m_tdata", 32'(m_tdata), 0);
    chk("async_rst_m_tlast", 32'(m_tlast), 0);
    chk("async_rst_s_tready", 32'(s_tready), 0);
    chk("async_rst_grant", 32'(grant), 0);
    chk("async_rst_stat", 32'(stat), 0);
    flush_bench();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    for (int p = 0; p < NP; p++) launch(p, 4);
    wait_quiet(500);
    launch(2, 2*ML);
    wait_quiet(500);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rx_stream_arbiter
`default_nettype wire
